// File: rtl/tipi_pkg.sv
// Shared definitions for the TIPI TI-side register port: register window
// addresses, FSM state encoding and the TI strobe bundle.
package tipi_pkg;

    localparam logic [15:0] TIPI_TC_ADDR = 16'h5FF9;
    localparam logic [15:0] TIPI_TD_ADDR = 16'h5FFB;
    localparam logic [15:0] TIPI_RC_ADDR = 16'h5FFD;
    localparam logic [15:0] TIPI_RD_ADDR = 16'h5FFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } tipi_state_e;

    typedef struct packed {
        logic memen_n;
        logic we_n;
        logic dbin;
    } tipi_strobe_t;

    // Bus-quiet strobe levels: no memory cycle, no write, no read.
    localparam tipi_strobe_t STROBE_IDLE = '{memen_n: 1'b1, we_n: 1'b1, dbin: 1'b0};

    function automatic logic is_read_addr(input logic [15:0] addr);
        return (addr == TIPI_RC_ADDR) || (addr == TIPI_RD_ADDR);
    endfunction

    function automatic logic is_write_addr(input logic [15:0] addr);
        return (addr == TIPI_TC_ADDR) || (addr == TIPI_TD_ADDR);
    endfunction

endpackage

// File: rtl/tipi_sync_filter.sv
// Multi-flop synchronizer followed by a stability filter: the whole vector is
// accepted only after it has held one value for FILTER consecutive cycles.
module tipi_sync_filter #(
    parameter int              WIDTH       = 8,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILTER      = 2,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int               CNT_W   = $clog2(FILTER + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // A change of the synchronized vector restarts the count at one, so a
    // value shorter than FILTER cycles never reaches the accepted register.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cand_d = cand_q;
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync_out == cand_q) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cand_d = sync_out;
            cnt_d  = CNT_W'(1);
        end
        if (cnt_d == CNT_MAX) begin
            filt_d = cand_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RESET_VAL;
            end
            cand_q <= RESET_VAL;
            cnt_q  <= CNT_MAX;
            filt_q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's old value.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/tipi_ti_reg_port.sv
// TI-99/4A side of the TIPI register window: decodes filtered TI memory
// cycles, commits writes into TD/TC and serves RD/RC reads back to the TI.
module tipi_ti_reg_port
    import tipi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cru_en,
    input  logic [15:0] ti_addr,
    input  logic        ti_memen_n,
    input  logic        ti_we_n,
    input  logic        ti_dbin,
    input  logic [7:0]  ti_din,
    output logic [7:0]  ti_dout,
    output logic        ti_dout_oe,
    input  logic [7:0]  RD,
    input  logic [7:0]  RC,
    output logic [7:0]  TD,
    output logic [7:0]  TC,
    output logic        rc_event
);

    logic [2:0]   strb_vec;
    tipi_strobe_t strb;
    logic [7:0]   rd_f;
    logic [7:0]   rc_f;

    tipi_sync_filter #(
        .WIDTH       (3),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER      (FILTER),
        .RESET_VAL   (STROBE_IDLE)
    ) u_strobe_filter (
        .clk   (clk),
        .reset (reset),
        .din   ({ti_memen_n, ti_we_n, ti_dbin}),
        .dout  (strb_vec)
    );

    tipi_sync_filter #(
        .WIDTH       (8),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER      (FILTER),
        .RESET_VAL   (8'h00)
    ) u_rd_filter (
        .clk   (clk),
        .reset (reset),
        .din   (RD),
        .dout  (rd_f)
    );

    tipi_sync_filter #(
        .WIDTH       (8),
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER      (FILTER),
        .RESET_VAL   (8'h00)
    ) u_rc_filter (
        .clk   (clk),
        .reset (reset),
        .din   (RC),
        .dout  (rc_f)
    );

    assign strb = strb_vec;

    logic memen_act;
    logic we_act;
    logic rd_sel;
    logic wr_sel;

    assign memen_act = ~strb.memen_n;
    assign we_act    = ~strb.we_n;
    assign rd_sel    = cru_en & memen_act & is_read_addr(ti_addr);
    assign wr_sel    = cru_en & memen_act & is_write_addr(ti_addr);

    tipi_state_e state_q, state_d;
    logic [7:0]  td_q, td_d;
    logic [7:0]  tc_q, tc_d;
    logic [7:0]  dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        wr_td_q, wr_td_d;
    logic        rd_rc_q, rd_rc_d;
    logic        rc_event_q, rc_event_d;
    logic [7:0]  rc_prev_q;
    logic        rc_set;
    logic        rc_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decode happens only from IDLE; once a cycle is in flight only the
    // filtered strobes can end it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_sel && strb.dbin) begin
                    state_d = READ;
                end else if (wr_sel && we_act) begin
                    state_d = WRITE;
                end
            end
            READ: begin
                if (!memen_act || !strb.dbin) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (!memen_act) begin
                    state_d = IDLE;
                end else if (!we_act) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!memen_act) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        td_d    = td_q;
        tc_d    = tc_q;
        dout_d  = dout_q;
        wr_td_d = wr_td_q;
        rd_rc_d = rd_rc_q;
        rc_clr  = 1'b0;
        oe_d    = (state_d == READ);
        case (state_q)
            IDLE: begin
                if (state_d == READ) begin
                    rd_rc_d = (ti_addr == TIPI_RC_ADDR);
                    dout_d  = (ti_addr == TIPI_RC_ADDR) ? rc_f : rd_f;
                end else if (state_d == WRITE) begin
                    wr_td_d = (ti_addr == TIPI_TD_ADDR);
                end
            end
            READ: begin
                rc_clr = (state_d == IDLE) && rd_rc_q;
            end
            WRITE: begin
                // ti_din is stable around the WE rising edge, so sample it here.
                if (state_d == HOLD) begin
                    if (wr_td_q) begin
                        td_d = ti_din;
                    end else begin
                        tc_d = ti_din;
                    end
                end
            end
            default: ;
        endcase
        rc_set     = (rc_f != rc_prev_q);
        rc_event_d = rc_set | (rc_event_q & ~rc_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            td_q       <= 8'h00;
            tc_q       <= 8'h00;
            dout_q     <= 8'h00;
            oe_q       <= 1'b0;
            wr_td_q    <= 1'b0;
            rd_rc_q    <= 1'b0;
            rc_event_q <= 1'b0;
            rc_prev_q  <= 8'h00;
        end else begin
            td_q       <= td_d;
            tc_q       <= tc_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
            wr_td_q    <= wr_td_d;
            rd_rc_q    <= rd_rc_d;
            rc_event_q <= rc_event_d;
            rc_prev_q  <= rc_f;
        end
    end

    assign TD         = td_q;
    assign TC         = tc_q;
    assign ti_dout    = dout_q;
    assign ti_dout_oe = oe_q;
    assign rc_event   = rc_event_q;

endmodule

// File: tb/tb_tipi_ti_reg_port.sv
// Directed bench for tipi_ti_reg_port: write commit timing, blocked writes,
// register reads, rc_event set/clear and reset abort.
module tb_tipi_ti_reg_port;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER      = 2;
    localparam int LAT         = SYNC_STAGES + FILTER;

    logic        clk = 1'b0;
    logic        reset;
    logic        cru_en;
    logic [15:0] ti_addr;
    logic        ti_memen_n;
    logic        ti_we_n;
    logic        ti_dbin;
    logic [7:0]  ti_din;
    logic [7:0]  ti_dout;
    logic        ti_dout_oe;
    logic [7:0]  RD;
    logic [7:0]  RC;
    logic [7:0]  TD;
    logic [7:0]  TC;
    logic        rc_event;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tipi_ti_reg_port #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER      (FILTER)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cru_en     (cru_en),
        .ti_addr    (ti_addr),
        .ti_memen_n (ti_memen_n),
        .ti_we_n    (ti_we_n),
        .ti_dbin    (ti_dbin),
        .ti_din     (ti_din),
        .ti_dout    (ti_dout),
        .ti_dout_oe (ti_dout_oe),
        .RD         (RD),
        .RC         (RC),
        .TD         (TD),
        .TC         (TC),
        .rc_event   (rc_event)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic cru);
        cru_en     = cru;
        ti_addr    = a;
        ti_din     = d;
        ti_memen_n = 1'b0;
        ti_we_n    = 1'b0;
        step(6);
        ti_we_n = 1'b1;
        step(7);
        ti_memen_n = 1'b1;
        step(7);
    endtask

    task automatic test_reset;
        step(3);
        checks++; if (TD !== 8'h00) begin errors++; $display("FAIL reset_td: got %h want 00", TD); end
        checks++; if (TC !== 8'h00) begin errors++; $display("FAIL reset_tc: got %h want 00", TC); end
        checks++; if (ti_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", ti_dout); end
        checks++; if (ti_dout_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", ti_dout_oe); end
        checks++; if (rc_event !== 1'b0) begin errors++; $display("FAIL reset_rc_event: got %b want 0", rc_event); end
        reset = 1'b1;
        step(2);
    endtask

    task automatic test_write_td;
        cru_en     = 1'b1;
        ti_addr    = 16'h5FFB;
        ti_din     = 8'hA5;
        ti_memen_n = 1'b0;
        ti_we_n    = 1'b0;
        step(6);
        ti_we_n = 1'b1;
        step(LAT);
        checks++; if (TD !== 8'h00) begin errors++; $display("FAIL write_td_early: got %h want 00", TD); end
        step(1);
        checks++; if (TD !== 8'hA5) begin errors++; $display("FAIL write_td_commit: got %h want a5", TD); end
        checks++; if (TC !== 8'h00) begin errors++; $display("FAIL write_td_tc_untouched: got %h want 00", TC); end
        ti_din = 8'hFF;
        step(4);
        checks++; if (TD !== 8'hA5) begin errors++; $display("FAIL write_td_single_commit: got %h want a5", TD); end
        ti_memen_n = 1'b1;
        step(8);
    endtask

    task automatic test_write_tc;
        do_write(16'h5FF9, 8'h77, 1'b1);
        checks++; if (TC !== 8'h77) begin errors++; $display("FAIL write_tc: got %h want 77", TC); end
        checks++; if (TD !== 8'hA5) begin errors++; $display("FAIL write_tc_td_untouched: got %h want a5", TD); end
    endtask

    task automatic test_reset_mid_write;
        do_write(16'h5FFB, 8'h11, 1'b1);
        checks++; if (TD !== 8'h11) begin errors++; $display("FAIL prereset_td: got %h want 11", TD); end
        ti_din     = 8'h22;
        ti_memen_n = 1'b0;
        ti_we_n    = 1'b0;
        step(6);
        reset = 1'b0;
        #1;
        checks++; if (TD !== 8'h00) begin errors++; $display("FAIL midreset_td: got %h want 00", TD); end
        checks++; if (TC !== 8'h00) begin errors++; $display("FAIL midreset_tc: got %h want 00", TC); end
        checks++; if (ti_dout_oe !== 1'b0) begin errors++; $display("FAIL midreset_oe: got %b want 0", ti_dout_oe); end
        checks++; if (rc_event !== 1'b0) begin errors++; $display("FAIL midreset_rc_event: got %b want 0", rc_event); end
        ti_we_n = 1'b1;
        step(3);
        ti_memen_n = 1'b1;
        step(3);
        reset = 1'b1;
        step(12);
        checks++; if (TD !== 8'h00) begin errors++; $display("FAIL postreset_no_commit: got %h want 00", TD); end
    endtask

    task automatic test_write_blocked;
        do_write(16'h5FF9, 8'h3C, 1'b0);
        checks++; if (TC !== 8'h00) begin errors++; $display("FAIL blocked_cru_off: got %h want 00", TC); end
        cru_en     = 1'b1;
        ti_addr    = 16'h5FF9;
        ti_din     = 8'h3C;
        ti_memen_n = 1'b0;
        step(6);
        ti_we_n = 1'b0;
        step(1);
        ti_we_n = 1'b1;
        step(8);
        ti_memen_n = 1'b1;
        step(7);
        checks++; if (TC !== 8'h00) begin errors++; $display("FAIL blocked_we_glitch: got %h want 00", TC); end
    endtask

    task automatic test_read_rd;
        RD = 8'h3C;
        step(6);
        cru_en     = 1'b1;
        ti_addr    = 16'h5FFF;
        ti_memen_n = 1'b0;
        ti_dbin    = 1'b1;
        step(LAT);
        checks++; if (ti_dout_oe !== 1'b0) begin errors++; $display("FAIL read_oe_early: got %b want 0", ti_dout_oe); end
        step(1);
        checks++; if (ti_dout_oe !== 1'b1) begin errors++; $display("FAIL read_oe_on: got %b want 1", ti_dout_oe); end
        checks++; if (ti_dout !== 8'h3C) begin errors++; $display("FAIL read_rd_data: got %h want 3c", ti_dout); end
        step(3);
        ti_dbin    = 1'b0;
        ti_memen_n = 1'b1;
        step(LAT);
        checks++; if (ti_dout_oe !== 1'b1) begin errors++; $display("FAIL read_oe_hold: got %b want 1", ti_dout_oe); end
        step(1);
        checks++; if (ti_dout_oe !== 1'b0) begin errors++; $display("FAIL read_oe_off: got %b want 0", ti_dout_oe); end
        checks++; if (ti_dout !== 8'h3C) begin errors++; $display("FAIL read_dout_hold: got %h want 3c", ti_dout); end
        step(4);
    endtask

    task automatic test_write_wrong_dir;
        do_write(16'h5FFF, 8'h99, 1'b1);
        checks++; if (TD !== 8'h00) begin errors++; $display("FAIL wrong_dir_td: got %h want 00", TD); end
        checks++; if (TC !== 8'h00) begin errors++; $display("FAIL wrong_dir_tc: got %h want 00", TC); end
    endtask

    task automatic test_rc_event;
        RC = 8'h5A;
        step(LAT);
        checks++; if (rc_event !== 1'b0) begin errors++; $display("FAIL rc_event_early: got %b want 0", rc_event); end
        step(1);
        checks++; if (rc_event !== 1'b1) begin errors++; $display("FAIL rc_event_set: got %b want 1", rc_event); end
        step(2);
        ti_addr    = 16'h5FFD;
        ti_memen_n = 1'b0;
        ti_dbin    = 1'b1;
        step(LAT + 1);
        checks++; if (ti_dout !== 8'h5A) begin errors++; $display("FAIL read_rc_data: got %h want 5a", ti_dout); end
        checks++; if (rc_event !== 1'b1) begin errors++; $display("FAIL rc_event_during_read: got %b want 1", rc_event); end
        step(3);
        ti_dbin    = 1'b0;
        ti_memen_n = 1'b1;
        step(LAT);
        checks++; if (rc_event !== 1'b1) begin errors++; $display("FAIL rc_event_before_exit: got %b want 1", rc_event); end
        step(1);
        checks++; if (rc_event !== 1'b0) begin errors++; $display("FAIL rc_event_clear: got %b want 0", rc_event); end
        step(4);
    endtask

    task automatic test_rc_race;
        RC = 8'h66;
        step(LAT + 2);
        checks++; if (rc_event !== 1'b1) begin errors++; $display("FAIL race_pre_set: got %b want 1", rc_event); end
        ti_addr    = 16'h5FFD;
        ti_memen_n = 1'b0;
        ti_dbin    = 1'b1;
        step(8);
        checks++; if (ti_dout !== 8'h66) begin errors++; $display("FAIL race_read_data: got %h want 66", ti_dout); end
        RC         = 8'hA5;
        ti_dbin    = 1'b0;
        ti_memen_n = 1'b1;
        step(LAT + 1);
        checks++; if (ti_dout_oe !== 1'b0) begin errors++; $display("FAIL race_oe_off: got %b want 0", ti_dout_oe); end
        checks++; if (rc_event !== 1'b1) begin errors++; $display("FAIL race_set_wins: got %b want 1", rc_event); end
        step(4);
        checks++; if (rc_event !== 1'b1) begin errors++; $display("FAIL race_sticky: got %b want 1", rc_event); end
        ti_memen_n = 1'b0;
        ti_dbin    = 1'b1;
        step(8);
        checks++; if (ti_dout !== 8'hA5) begin errors++; $display("FAIL race_reread_data: got %h want a5", ti_dout); end
        ti_dbin    = 1'b0;
        ti_memen_n = 1'b1;
        step(LAT + 1);
        checks++; if (rc_event !== 1'b0) begin errors++; $display("FAIL race_reread_clear: got %b want 0", rc_event); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        cru_en     = 1'b0;
        ti_addr    = 16'h0000;
        ti_memen_n = 1'b1;
        ti_we_n    = 1'b1;
        ti_dbin    = 1'b0;
        ti_din     = 8'h00;
        RD         = 8'h00;
        RC         = 8'h00;

        test_reset();
        test_write_td();
        test_write_tc();
        test_reset_mid_write();
        test_write_blocked();
        test_read_rd();
        test_write_wrong_dir();
        test_rc_event();
        test_rc_race();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
